// File: rtl/comm_assist_pkg.sv
// Shared encodings for the communication-assist node: flit ctrl codes,
// download-target indices and the idle download-register state.
package comm_assist_pkg;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  localparam int DST_IC  = 0;
  localparam int DST_DC  = 1;
  localparam int DST_MEM = 2;

  localparam logic [4:0] INSTREP_CMD_DFLT = 5'b10100;

  localparam logic [1:0] DL_IDLE = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins,
// and ptr_nxt_o points just past the winner for the owner's pointer register.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   win_o,
  output logic               gnt_v_o,
  output logic [PTR_W-1:0]   ptr_nxt_o
);

  int idx;

  always_comb begin
    gnt_o     = '0;
    win_o     = '0;
    gnt_v_o   = 1'b0;
    ptr_nxt_o = ptr_i;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (!gnt_v_o && req_i[idx]) begin
        gnt_v_o    = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = PTR_W'(idx);
        ptr_nxt_o  = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/in_node_flit_dispatcher.sv
// Input-side flit dispatcher: locks wormhole packets from NUM_SRC channels onto
// NUM_DST download targets. Optional per-target tail counters: DISP_PKT_CNT_EN.
module in_node_flit_dispatcher
  import comm_assist_pkg::*;
#(
  parameter int FLIT_W  = 16,
  parameter int NUM_SRC = 2,
  parameter int NUM_DST = 3,
  parameter int CMD_LSB = 5,
  parameter int CMD_W   = 5,
  parameter logic [CMD_W-1:0] INSTREP_CMD = CMD_W'(INSTREP_CMD_DFLT),
  parameter int MEM_BIT = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_v_i,
  input  logic [2*NUM_SRC-1:0]      src_ctrl_i,
  input  logic [FLIT_W*NUM_SRC-1:0] src_flit_i,
  output logic [NUM_SRC-1:0]        src_ack_o,
  input  logic [2*NUM_DST-1:0]      dst_state_i,
  input  logic [NUM_DST-1:0]        dst_rdy_i,
  output logic [NUM_DST-1:0]        dst_v_o,
  output logic [FLIT_W*NUM_DST-1:0] dst_flit_o,
  output logic [2*NUM_DST-1:0]      dst_ctrl_o,
  output logic [NUM_DST-1:0]        dst_busy_o
`ifdef DISP_PKT_CNT_EN
  ,
  output logic [16*NUM_DST-1:0]     pkt_cnt_o
`endif
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int DST_W = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;

  logic [NUM_DST-1:0] own_v_q, own_v_d;
  logic [SRC_W-1:0]   own_src_q [NUM_DST];
  logic [SRC_W-1:0]   own_src_d [NUM_DST];
  logic [NUM_SRC-1:0] lock_v_q, lock_v_d;
  logic [DST_W-1:0]   lock_dst_q [NUM_SRC];
  logic [DST_W-1:0]   lock_dst_d [NUM_SRC];
  logic [SRC_W-1:0]   rr_q [NUM_DST];
  logic [SRC_W-1:0]   rr_d [NUM_DST];

  logic [DST_W-1:0]   hd_dst [NUM_SRC];
  logic [NUM_SRC-1:0] lk_xfer, lk_tail;
  logic [NUM_SRC-1:0] req [NUM_DST];
  logic [NUM_SRC-1:0] gnt [NUM_DST];
  logic [SRC_W-1:0]   win [NUM_DST];
  logic [SRC_W-1:0]   ptr_nxt [NUM_DST];
  logic [NUM_DST-1:0] gnt_v;

  // Only the reply channel can reach the inst cache; requests split on MEM_BIT.
  always_comb begin
    lk_xfer = '0;
    lk_tail = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      hd_dst[s] = src_flit_i[s*FLIT_W + MEM_BIT] ? DST_W'(DST_MEM) : DST_W'(DST_DC);
      if (s == 0 && src_flit_i[CMD_LSB +: CMD_W] == INSTREP_CMD)
        hd_dst[s] = DST_W'(DST_IC);
      lk_xfer[s] = lock_v_q[s] && src_v_i[s] && dst_rdy_i[lock_dst_q[s]] &&
                   (src_ctrl_i[2*s +: 2] == CTRL_BODY || src_ctrl_i[2*s +: 2] == CTRL_TAIL);
      lk_tail[s] = lk_xfer[s] && (src_ctrl_i[2*s +: 2] == CTRL_TAIL);
    end
    for (int d = 0; d < NUM_DST; d++) begin
      req[d] = '0;
      for (int s = 0; s < NUM_SRC; s++)
        req[d][s] = src_v_i[s] && (src_ctrl_i[2*s +: 2] == CTRL_HEAD) && !lock_v_q[s] &&
                    (hd_dst[s] == DST_W'(d)) && !own_v_q[d] &&
                    (dst_state_i[2*d +: 2] == DL_IDLE) && dst_rdy_i[d];
    end
  end

  for (genvar d = 0; d < NUM_DST; d++) begin : g_arb
    rr_arbiter #(
      .NUM_REQ(NUM_SRC),
      .PTR_W  (SRC_W)
    ) u_arb (
      .req_i    (req[d]),
      .ptr_i    (rr_q[d]),
      .gnt_o    (gnt[d]),
      .win_o    (win[d]),
      .gnt_v_o  (gnt_v[d]),
      .ptr_nxt_o(ptr_nxt[d])
    );
  end

  always_comb begin
    src_ack_o  = lk_xfer;
    dst_v_o    = '0;
    dst_flit_o = '0;
    dst_ctrl_o = {NUM_DST{CTRL_IDLE}};
    for (int d = 0; d < NUM_DST; d++) begin
      if (own_v_q[d]) begin
        if (lk_xfer[own_src_q[d]]) begin
          dst_v_o[d]                  = 1'b1;
          dst_flit_o[d*FLIT_W +: FLIT_W] = src_flit_i[int'(own_src_q[d])*FLIT_W +: FLIT_W];
          dst_ctrl_o[2*d +: 2]        = src_ctrl_i[int'(own_src_q[d])*2 +: 2];
        end
      end else if (gnt_v[d]) begin
        src_ack_o                   = src_ack_o | gnt[d];
        dst_v_o[d]                  = 1'b1;
        dst_flit_o[d*FLIT_W +: FLIT_W] = src_flit_i[int'(win[d])*FLIT_W +: FLIT_W];
        dst_ctrl_o[2*d +: 2]        = CTRL_HEAD;
      end
    end
  end

  assign dst_busy_o = own_v_q;

  // A head grant and a tail release never touch the same source or target in one cycle.
  always_comb begin
    own_v_d    = own_v_q;
    own_src_d  = own_src_q;
    lock_v_d   = lock_v_q;
    lock_dst_d = lock_dst_q;
    rr_d       = rr_q;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (lk_tail[s]) begin
        lock_v_d[s]              = 1'b0;
        own_v_d[lock_dst_q[s]]   = 1'b0;
      end
    end
    for (int d = 0; d < NUM_DST; d++) begin
      if (gnt_v[d]) begin
        own_v_d[d]           = 1'b1;
        own_src_d[d]         = win[d];
        lock_v_d[win[d]]     = 1'b1;
        lock_dst_d[win[d]]   = DST_W'(d);
        rr_d[d]              = ptr_nxt[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_v_q  <= '0;
      lock_v_q <= '0;
      for (int d = 0; d < NUM_DST; d++) begin
        own_src_q[d] <= '0;
        rr_q[d]      <= '0;
      end
      for (int s = 0; s < NUM_SRC; s++)
        lock_dst_q[s] <= '0;
    end else begin
      own_v_q    <= own_v_d;
      own_src_q  <= own_src_d;
      lock_v_q   <= lock_v_d;
      lock_dst_q <= lock_dst_d;
      rr_q       <= rr_d;
    end
  end

`ifdef DISP_PKT_CNT_EN
  logic [16*NUM_DST-1:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int d = 0; d < NUM_DST; d++)
        if (dst_v_o[d] && dst_ctrl_o[2*d +: 2] == CTRL_TAIL)
          pkt_cnt_q[16*d +: 16] <= pkt_cnt_q[16*d +: 16] + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_in_node_flit_dispatcher.sv
// Bench for in_node_flit_dispatcher: directed scenarios then random traffic,
// all checked cycle by cycle against a packet-level ownership model.
module tb_in_node_flit_dispatcher;

  localparam int FW = 16;
  localparam int NS = 2;
  localparam int ND = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   src_v;
  logic [2*NS-1:0] src_ctrl;
  logic [FW*NS-1:0] src_flit;
  logic [NS-1:0]   src_ack;
  logic [2*ND-1:0] dst_state;
  logic [ND-1:0]   dst_rdy;
  logic [ND-1:0]   dst_v;
  logic [FW*ND-1:0] dst_flit;
  logic [2*ND-1:0] dst_ctrl;
  logic [ND-1:0]   dst_busy;
`ifdef DISP_PKT_CNT_EN
  logic [16*ND-1:0] pkt_cnt;
`endif

  always #5 clk = ~clk;

  in_node_flit_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .src_v_i    (src_v),
    .src_ctrl_i (src_ctrl),
    .src_flit_i (src_flit),
    .src_ack_o  (src_ack),
    .dst_state_i(dst_state),
    .dst_rdy_i  (dst_rdy),
    .dst_v_o    (dst_v),
    .dst_flit_o (dst_flit),
    .dst_ctrl_o (dst_ctrl),
    .dst_busy_o (dst_busy)
`ifdef DISP_PKT_CNT_EN
    ,
    .pkt_cnt_o  (pkt_cnt)
`endif
  );

  // model: who owns what, round-robin pointers, tail counts
  int          m_own  [ND];
  int          m_lock [NS];
  int          m_rr   [ND];
  int unsigned m_cnt  [ND];

  logic [FW-1:0] q_f [NS][$];
  logic [1:0]    q_c [NS][$];
  bit            go    [NS];
  bit            inj   [NS];
  logic [1:0]    inj_c [NS];

  int          total = 0;
  int          bad   = 0;
  logic [NS-1:0] last_ack;
  int          dv_cnt [ND];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tgt(input int s, input logic [FW-1:0] f);
    if (s == 0 && f[9:5] == 5'b10100) return 0;
    return f[13] ? 2 : 1;
  endfunction

  task automatic push_pkt(input int s, input int d, input int len);
    logic [FW-1:0] f;
    f = FW'($urandom);
    if (d == 0) f[9:5] = 5'b10100;
    else begin
      if (s == 0 && f[9:5] == 5'b10100) f[9:5] = 5'b00000;
      f[13] = (d == 2);
    end
    q_f[s].push_back(f);
    q_c[s].push_back(2'b01);
    for (int i = 0; i < len - 2; i++) begin
      q_f[s].push_back(FW'($urandom));
      q_c[s].push_back(2'b10);
    end
    q_f[s].push_back(FW'($urandom));
    q_c[s].push_back(2'b11);
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin m_own[d] = -1; m_rr[d] = 0; m_cnt[d] = 0; end
    for (int s = 0; s < NS; s++) begin
      m_lock[s] = -1;
      q_f[s].delete();
      q_c[s].delete();
    end
  endtask

  task automatic cyc();
    logic [NS-1:0]    e_ack;
    logic [ND-1:0]    e_v, e_busy;
    logic [FW*ND-1:0] e_f;
    logic [2*ND-1:0]  e_c;
    int               gw [ND];
    bit               tl [NS];
    int               d, s;
    for (int i = 0; i < NS; i++) begin
      if (inj[i]) begin
        src_v[i] = 1'b1; src_ctrl[2*i +: 2] = inj_c[i]; src_flit[FW*i +: FW] = FW'($urandom);
      end else if (go[i] && q_f[i].size() > 0) begin
        src_v[i] = 1'b1; src_ctrl[2*i +: 2] = q_c[i][0]; src_flit[FW*i +: FW] = q_f[i][0];
      end else begin
        src_v[i] = 1'b0; src_ctrl[2*i +: 2] = 2'b00; src_flit[FW*i +: FW] = '0;
      end
    end
    #1;
    e_ack = '0; e_v = '0; e_f = '0; e_c = '0; e_busy = '0;
    for (int i = 0; i < NS; i++) begin
      tl[i] = 0;
      if (m_lock[i] >= 0) begin
        d = m_lock[i];
        if (src_v[i] && src_ctrl[2*i +: 2] >= 2'b10 && dst_rdy[d]) begin
          e_ack[i] = 1'b1; e_v[d] = 1'b1;
          e_f[FW*d +: FW] = src_flit[FW*i +: FW];
          e_c[2*d +: 2] = src_ctrl[2*i +: 2];
          tl[i] = (src_ctrl[2*i +: 2] == 2'b11);
        end
      end
    end
    for (int j = 0; j < ND; j++) begin
      gw[j] = -1;
      e_busy[j] = (m_own[j] >= 0);
      if (m_own[j] < 0 && dst_state[2*j +: 2] == 2'b00 && dst_rdy[j]) begin
        for (int k = 0; k < NS; k++) begin
          s = (m_rr[j] + k) % NS;
          if (gw[j] < 0 && src_v[s] && src_ctrl[2*s +: 2] == 2'b01 && m_lock[s] < 0 &&
              tgt(s, src_flit[FW*s +: FW]) == j)
            gw[j] = s;
        end
      end
      if (gw[j] >= 0) begin
        e_ack[gw[j]] = 1'b1; e_v[j] = 1'b1;
        e_f[FW*j +: FW] = src_flit[FW*gw[j] +: FW];
        e_c[2*j +: 2] = 2'b01;
      end
    end
    chk("src_ack", 64'(src_ack), 64'(e_ack));
    chk("dst_v", 64'(dst_v), 64'(e_v));
    chk("dst_flit", 64'(dst_flit), 64'(e_f));
    chk("dst_ctrl", 64'(dst_ctrl), 64'(e_c));
    chk("dst_busy", 64'(dst_busy), 64'(e_busy));
`ifdef DISP_PKT_CNT_EN
    for (int j = 0; j < ND; j++)
      chk("pkt_cnt", 64'(pkt_cnt[16*j +: 16]), 64'(m_cnt[j] % 65536));
`endif
    last_ack = src_ack;
    for (int j = 0; j < ND; j++) dv_cnt[j] += int'(dst_v[j]);
    for (int i = 0; i < NS; i++) begin
      if (tl[i]) begin
        m_cnt[m_lock[i]]++;
        m_own[m_lock[i]] = -1;
        m_lock[i] = -1;
      end
    end
    for (int j = 0; j < ND; j++) begin
      if (gw[j] >= 0) begin
        m_own[j] = gw[j]; m_lock[gw[j]] = j; m_rr[j] = (gw[j] + 1) % NS;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (e_ack[i] && !inj[i]) begin
        void'(q_f[i].pop_front());
        void'(q_c[i].pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_empty(input string tag, input int bound);
    int n = 0;
    while ((q_f[0].size() + q_f[1].size()) > 0 && n < bound) begin cyc(); n++; end
    chk(tag, 64'(q_f[0].size() + q_f[1].size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_v = '0; src_ctrl = '0; src_flit = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 64'(dst_busy), 64'd0);
    chk("rst_dst_v", 64'(dst_v), 64'd0);
    chk("rst_ack", 64'(src_ack), 64'd0);
`ifdef DISP_PKT_CNT_EN
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
  endtask

  logic [1:0] t2e [6];

  initial begin
    dst_state = '0;
    dst_rdy   = '1;
    for (int i = 0; i < NS; i++) begin go[i] = 1; inj[i] = 0; inj_c[i] = 2'b00; end
    for (int j = 0; j < ND; j++) dv_cnt[j] = 0;
    do_reset();

    // reply to inst cache, 4 flits
    push_pkt(0, 0, 4);
    dv_cnt[0] = 0;
    run_empty("t1_timeout", 20);
    chk("t1_dv0_cnt", 64'(dv_cnt[0]), 64'd4);
    #1 chk("t1_busy_clr", 64'(dst_busy[0]), 64'd0);

    // contention on dc: src0 first, then src1 wins the re-contention
    t2e[0] = 2'b01; t2e[1] = 2'b01; t2e[2] = 2'b10;
    t2e[3] = 2'b10; t2e[4] = 2'b01; t2e[5] = 2'b01;
    push_pkt(0, 1, 2); push_pkt(1, 1, 2); push_pkt(0, 1, 2);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("t2_ack%0d", i), 64'(last_ack), 64'(t2e[i]));
    end
    run_empty("t2_timeout", 10);

    // independent streams dc and mem
    push_pkt(0, 1, 4); push_pkt(1, 2, 4);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("t3_ack%0d", i), 64'(last_ack), 64'd3);
    end
    run_empty("t3_timeout", 10);

    // mem back-pressure mid-packet
    push_pkt(1, 2, 5);
    dv_cnt[2] = 0;
    cyc(); cyc();
    dst_rdy[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t4_hold%0d", i), 64'(last_ack), 64'd0);
    end
    dst_rdy[2] = 1'b1;
    run_empty("t4_timeout", 10);
    chk("t4_dv2_cnt", 64'(dv_cnt[2]), 64'd5);

    // dc download register busy
    dst_state[3:2] = 2'b01;
    push_pkt(0, 1, 3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t5_wait%0d", i), 64'(last_ack), 64'd0);
    end
    dst_state[3:2] = 2'b00;
    cyc();
    chk("t5_grant", 64'(last_ack), 64'd1);
    run_empty("t5_timeout", 10);

    // reset mid-packet, then three fresh packets
    push_pkt(0, 1, 5);
    cyc(); cyc();
    do_reset();
    push_pkt(0, 1, 2); push_pkt(0, 1, 2); push_pkt(0, 1, 2);
    cyc();
    chk("t6_head_after_rst", 64'(last_ack), 64'd1);
    run_empty("t6_timeout", 20);
`ifdef DISP_PKT_CNT_EN
    chk("t6_pkt_cnt_dc", 64'(pkt_cnt[31:16]), 64'd3);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) begin
        if (q_f[i].size() == 0 && $urandom_range(3) == 0)
          push_pkt(i, (i == 0) ? int'($urandom_range(2)) : int'($urandom_range(2, 1)),
                   int'($urandom_range(5, 2)));
        go[i] = ($urandom_range(3) != 0);
        if ($urandom_range(9) == 0) begin
          inj[i]   = 1;
          inj_c[i] = (m_lock[i] >= 0 && $urandom_range(1) == 1) ? 2'b01 : 2'b00;
        end else begin
          inj[i] = 0;
        end
      end
      for (int j = 0; j < ND; j++) begin
        dst_rdy[j] = ($urandom_range(4) != 0);
        dst_state[2*j +: 2] = ($urandom_range(7) == 0) ? 2'b01 : 2'b00;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
